// File: rtl/thread_fetch_seq_if.sv
// Bundle between the thread sequencer and its neighbours.
// The FETCH request side carries f_enable, f_write_mode, f_addr, f_thread,
// f_data and f_ack. The decode side carries instr, instr_pc, instr_thread,
// instr_valid and instr_ready.
// master: the sequencer. slave: FETCH together with decode.
interface thread_fetch_seq_if #(
  parameter int unsigned TW = 2
);
  logic          f_enable;
  logic          f_write_mode;
  logic [31:0]   f_addr;
  logic [TW-1:0] f_thread;
  logic [31:0]   f_data;
  logic          f_ack;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic [TW-1:0] instr_thread;
  logic          instr_valid;
  logic          instr_ready;

  modport master (
    output f_enable, f_write_mode, f_addr, f_thread,
    output instr, instr_pc, instr_thread, instr_valid,
    input  f_data, f_ack, instr_ready
  );

  modport slave (
    input  f_enable, f_write_mode, f_addr, f_thread,
    input  instr, instr_pc, instr_thread, instr_valid,
    output f_data, f_ack, instr_ready
  );
endinterface

// File: rtl/thread_fetch_seq.sv
// Upstream sequencer for the FETCH unit.
// It keeps one PC per hardware thread and picks the next enabled, non-faulted
// thread in round-robin order. It issues one word read at a time over the
// FETCH enable/ack interface. Each returned word goes to decode over
// valid/ready. Execute can redirect a thread's PC through pc_wr.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   thread_en       per-thread run enable
//   bus (master)    FETCH request and decode handshake
//   pc_wr*          redirect strobe, target thread and new PC
//   fault           sticky per-thread illegal-PC flag
module thread_fetch_seq #(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned TW       = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] REG_BASE = 32'hFFFF_FFF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NTHREADS-1:0] thread_en,
  thread_fetch_seq_if.master  bus,
  input  logic                pc_wr,
  input  logic [TW-1:0]       pc_wr_thread,
  input  logic [31:0]         pc_wr_val,
  output logic [NTHREADS-1:0] fault
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q [NTHREADS];
  logic [TW-1:0] rr_q;
  logic          gap_q;
  logic          discard_q;
  logic          f_enable_q;
  logic [31:0]   f_addr_q;
  logic [TW-1:0] f_thread_q;
  logic [31:0]   instr_q;
  logic [31:0]   instr_pc_q;
  logic [TW-1:0] instr_thread_q;
  logic          instr_valid_q;

  logic          found;
  logic [TW-1:0] sel;
  logic [TW-1:0] cand;
  logic          sel_illegal;
  logic          wr_hits_sel;
  logic          wr_hits_req;
  logic          wr_hits_hold;
  logic          issue, mark_fault, deliver, drop_ack;

  // Round-robin scan starting just after the last thread that was served.
  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    cand  = rr_q;
    for (int unsigned i = 1; i <= NTHREADS; i++) begin
      cand = rr_q + TW'(i);
      if (!found && thread_en[cand] && !fault[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign sel_illegal  = (pc_q[sel] >= REG_BASE);
  assign wr_hits_sel  = pc_wr && (pc_wr_thread == sel);
  assign wr_hits_req  = pc_wr && (pc_wr_thread == f_thread_q);
  assign wr_hits_hold = pc_wr && (pc_wr_thread == instr_thread_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A redirect that lands on the selected thread in the same cycle skips
  // selection, so a stale PC is never issued. gap_q holds IDLE for one extra
  // cycle after a dropped ack. This keeps f_enable low for two cycles on that
  // path, the same as after a delivered instruction.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    mark_fault = 1'b0;
    deliver    = 1'b0;
    drop_ack   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!gap_q && found && !wr_hits_sel) begin
          if (sel_illegal) begin
            mark_fault = 1'b1;
          end else begin
            issue   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.f_ack) begin
          if (discard_q || wr_hits_req) begin
            drop_ack = 1'b1;
            state_d  = IDLE;
          end else begin
            deliver = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.instr_ready || wr_hits_hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q           <= TW'(NTHREADS - 1);
      gap_q          <= 1'b0;
      discard_q      <= 1'b0;
      f_enable_q     <= 1'b0;
      f_addr_q       <= '0;
      f_thread_q     <= '0;
      instr_q        <= '0;
      instr_pc_q     <= '0;
      instr_thread_q <= '0;
      instr_valid_q  <= 1'b0;
      fault          <= '0;
      for (int unsigned t = 0; t < NTHREADS; t++) pc_q[t] <= RESET_PC;
    end else begin
      gap_q <= drop_ack;
      if (issue) begin
        f_enable_q <= 1'b1;
        f_addr_q   <= pc_q[sel];
        f_thread_q <= sel;
        rr_q       <= sel;
        discard_q  <= 1'b0;
      end
      if (mark_fault) rr_q <= sel;
      // A redirect to the in-flight thread poisons the pending response.
      if (state_q == REQ && wr_hits_req) discard_q <= 1'b1;
      if (deliver) begin
        instr_q        <= bus.f_data;
        instr_pc_q     <= f_addr_q;
        instr_thread_q <= f_thread_q;
        instr_valid_q  <= 1'b1;
        f_enable_q     <= 1'b0;
      end
      if (drop_ack) f_enable_q <= 1'b0;
      if (state_q == HOLD && state_d == IDLE) instr_valid_q <= 1'b0;
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        if (pc_wr && pc_wr_thread == TW'(t)) begin
          pc_q[t]  <= pc_wr_val;
          fault[t] <= 1'b0;
        end else begin
          if (deliver && f_thread_q == TW'(t)) pc_q[t] <= pc_q[t] + 32'd1;
          if (mark_fault && sel == TW'(t))     fault[t] <= 1'b1;
        end
      end
    end
  end

  assign bus.f_enable     = f_enable_q;
  assign bus.f_write_mode = 1'b0;
  assign bus.f_addr       = f_addr_q;
  assign bus.f_thread     = f_thread_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.instr_thread = instr_thread_q;
  assign bus.instr_valid  = instr_valid_q;

endmodule

// File: tb/tb_thread_fetch_seq.sv
module tb_thread_fetch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] thread_en;
  logic       pc_wr;
  logic [1:0] pc_wr_thread;
  logic [31:0] pc_wr_val;
  logic [3:0] fault;

  int checks = 0;
  int errors = 0;

  thread_fetch_seq_if #(.TW(2)) bus ();

  thread_fetch_seq #(
    .NTHREADS(4),
    .TW(2),
    .RESET_PC(32'h0000_0000),
    .REG_BASE(32'hFFFF_FFF0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .thread_en(thread_en),
    .bus(bus),
    .pc_wr(pc_wr),
    .pc_wr_thread(pc_wr_thread),
    .pc_wr_val(pc_wr_val),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic apply_reset(input logic [3:0] en);
    rst             = 1'b1;
    thread_en       = en;
    pc_wr           = 1'b0;
    pc_wr_thread    = '0;
    pc_wr_val       = '0;
    bus.f_ack       = 1'b0;
    bus.f_data      = '0;
    bus.instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait up to 20 cycles for a request. The caller must treat ok=0 as a failure.
  task automatic wait_fen(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.f_enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack(input logic [31:0] data);
    bus.f_ack  = 1'b1;
    bus.f_data = data;
    @(negedge clk);
    bus.f_ack  = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(4'b0001);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.f_enable !== 1'b0 || bus.instr_valid !== 1'b0 || fault !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got fen=%b iv=%b fault=%b want 0 0 0000",
               bus.f_enable, bus.instr_valid, fault);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.f_enable !== 1'b1 || bus.f_addr !== 32'd0 || bus.f_thread !== 2'd0) begin
      errors++;
      $display("FAIL first_req got fen=%b addr=%h thr=%0d want 1 0 0",
               bus.f_enable, bus.f_addr, bus.f_thread);
    end
    ack(32'hDEAD_0001);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hDEAD_0001 || bus.instr_pc !== 32'd0 ||
        bus.instr_thread !== 2'd0 || bus.f_enable !== 1'b0) begin
      errors++;
      $display("FAIL first_instr got iv=%b instr=%h pc=%h thr=%0d fen=%b want 1 dead0001 0 0 0",
               bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_thread, bus.f_enable);
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_accept got iv=%b want 0", bus.instr_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.f_enable !== 1'b1 || bus.f_addr !== 32'd1) begin
      errors++;
      $display("FAIL second_req got fen=%b addr=%h want 1 00000001", bus.f_enable, bus.f_addr);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp_thr  [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0] exp_addr [4] = '{32'd0, 32'd0, 32'd1, 32'd1};
    bit ok;
    apply_reset(4'b0101);
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_fen(ok);
      checks++;
      if (!ok || bus.f_thread !== exp_thr[k] || bus.f_addr !== exp_addr[k]) begin
        errors++;
        $display("FAIL rr_req%0d got ok=%b thr=%0d addr=%h want 1 %0d %h",
                 k, ok, bus.f_thread, bus.f_addr, exp_thr[k], exp_addr[k]);
      end
      ack(32'hA000_0000 + 32'(k));
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hA000_0000 + 32'(k) ||
          bus.instr_thread !== exp_thr[k]) begin
        errors++;
        $display("FAIL rr_instr%0d got iv=%b instr=%h thr=%0d want 1 %h %0d",
                 k, bus.instr_valid, bus.instr, bus.instr_thread,
                 32'hA000_0000 + 32'(k), exp_thr[k]);
      end
    end
  endtask

  task automatic test_hold_stall;
    bit ok;
    bit bad = 1'b0;
    apply_reset(4'b0001);
    wait_fen(ok);
    ack(32'h1234_5678);
    for (int c = 0; c < 5; c++) begin
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1234_5678 || bus.instr_pc !== 32'd0 ||
          bus.instr_thread !== 2'd0 || bus.f_enable !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!ok || bad) begin
      errors++;
      $display("FAIL hold_stable got ok=%b iv=%b instr=%h pc=%h fen=%b want stable 1 12345678 0 0",
               ok, bus.instr_valid, bus.instr, bus.instr_pc, bus.f_enable);
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got iv=%b want 0", bus.instr_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.f_enable !== 1'b1 || bus.f_addr !== 32'd1) begin
      errors++;
      $display("FAIL hold_next got iv=%b fen=%b addr=%h want 0 1 00000001",
               bus.instr_valid, bus.f_enable, bus.f_addr);
    end
  endtask

  task automatic test_redirect_ack;
    bit ok;
    apply_reset(4'b0000);
    bus.instr_ready = 1'b1;
    pc_wr = 1'b1; pc_wr_thread = 2'd1; pc_wr_val = 32'd5;
    @(negedge clk);
    pc_wr = 1'b0;
    thread_en = 4'b0010;
    wait_fen(ok);
    checks++;
    if (!ok || bus.f_addr !== 32'd5 || bus.f_thread !== 2'd1) begin
      errors++;
      $display("FAIL redir_req got ok=%b addr=%h thr=%0d want 1 00000005 1",
               ok, bus.f_addr, bus.f_thread);
    end
    pc_wr = 1'b1; pc_wr_thread = 2'd1; pc_wr_val = 32'h40;
    ack(32'hBAD0_BAD0);
    pc_wr = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.f_enable !== 1'b0) begin
      errors++;
      $display("FAIL redir_drop got iv=%b fen=%b want 0 0", bus.instr_valid, bus.f_enable);
    end
    wait_fen(ok);
    checks++;
    if (!ok || bus.f_addr !== 32'h40 || bus.f_thread !== 2'd1 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_next got ok=%b addr=%h thr=%0d iv=%b want 1 00000040 1 0",
               ok, bus.f_addr, bus.f_thread, bus.instr_valid);
    end
  endtask

  task automatic test_fault;
    bit ok;
    bit saw_fen = 1'b0;
    apply_reset(4'b0000);
    bus.instr_ready = 1'b1;
    pc_wr = 1'b1; pc_wr_thread = 2'd3; pc_wr_val = 32'hFFFF_FFF2;
    @(negedge clk);
    pc_wr = 1'b0;
    thread_en = 4'b1000;
    @(negedge clk);
    checks++;
    if (fault !== 4'b1000) begin
      errors++;
      $display("FAIL fault_set got fault=%b want 1000", fault);
    end
    for (int c = 0; c < 6; c++) begin
      if (bus.f_enable !== 1'b0) saw_fen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_fen) begin
      errors++;
      $display("FAIL fault_block got f_enable=1 want 0 throughout");
    end
    pc_wr = 1'b1; pc_wr_thread = 2'd3; pc_wr_val = 32'h10;
    @(negedge clk);
    pc_wr = 1'b0;
    checks++;
    if (fault !== 4'b0000) begin
      errors++;
      $display("FAIL fault_clear got fault=%b want 0000", fault);
    end
    wait_fen(ok);
    checks++;
    if (!ok || bus.f_addr !== 32'h10 || bus.f_thread !== 2'd3) begin
      errors++;
      $display("FAIL fault_resume got ok=%b addr=%h thr=%0d want 1 00000010 3",
               ok, bus.f_addr, bus.f_thread);
    end
  endtask

  task automatic test_reset_mid_req;
    bit ok;
    apply_reset(4'b0001);
    bus.instr_ready = 1'b1;
    wait_fen(ok);
    ack(32'h0);
    wait_fen(ok);
    checks++;
    if (!ok || bus.f_addr !== 32'd1) begin
      errors++;
      $display("FAIL midrst_pre got ok=%b addr=%h want 1 00000001", ok, bus.f_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.f_enable !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got fen=%b iv=%b want 0 0", bus.f_enable, bus.instr_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.f_enable !== 1'b1 || bus.f_addr !== 32'd0 || bus.f_thread !== 2'd0) begin
      errors++;
      $display("FAIL midrst_pc got fen=%b addr=%h thr=%0d want 1 0 0",
               bus.f_enable, bus.f_addr, bus.f_thread);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold_stall();
    test_redirect_ack();
    test_fault();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thread_fetch_seq.md
Name: thread_fetch_seq

Overview:
- Upstream sequencer for the FETCH unit.
- Keeps one program counter per hardware thread and picks the next enabled thread round-robin.
- Issues word reads through FETCH's enable/ack request interface.
- Hands each returned instruction to decode over a valid/ready handshake; accepts branch redirects from execute.

Parameters:
NTHREADS, 4, number of hardware threads (2^TW)
TW, 2, thread index width
RESET_PC, 32'h0000_0000, PC value of every thread after reset
REG_BASE, 32'hFFFF_FFF0, start of register-mapped window; PCs at or above it are illegal

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
thread_en  in  NTHREADS  per-thread run enable
f_enable  out  1  request strobe to FETCH
f_write_mode  out  1  always 0 (reads only)
f_addr  out  32  fetch address (selected PC)
f_thread  out  TW  thread of current request
f_data  in  32  FETCH read data, valid with f_ack
f_ack  in  1  FETCH completion
instr  out  32  fetched instruction
instr_pc  out  32  PC of instr
instr_thread  out  TW  thread of instr
instr_valid  out  1  instr present
instr_ready  in  1  decode accepts instr
pc_wr  in  1  redirect strobe
pc_wr_thread  in  TW  redirect target thread
pc_wr_val  in  32  new PC
fault  out  NTHREADS  sticky illegal-PC flag per thread

Behaviour:
- Reset is asynchronous and active-high (rst); clock is clk.
- On reset, all outputs go to 0 immediately (including f_enable and instr_valid), every pc to RESET_PC, fault to 0, rr pointer to thread NTHREADS-1 (so thread 0 is served first).
- Registered FSM with states IDLE, REQ, HOLD.
- IDLE:
  - Scan threads from rr+1 upward (mod NTHREADS) for the first t with thread_en[t]=1 and fault[t]=0.
  - None found: stay in IDLE.
  - pc[t] >= REG_BASE: set fault[t], rr<=t, stay in IDLE, issue nothing.
  - Otherwise, at the next edge: f_enable<=1, f_addr<=pc[t], f_thread<=t, rr<=t, go to REQ.
- REQ:
  - Outputs are held stable until f_ack.
  - On an edge with f_ack=1: instr<=f_data, instr_pc<=f_addr, instr_thread<=f_thread, instr_valid<=1, f_enable<=0, pc[t]<=pc[t]+1 (mod 2^32), go to HOLD.
  - thread_en deasserting during REQ does not abort the request.
- HOLD:
  - instr, instr_pc and instr_thread are stable while instr_valid=1.
  - On an edge with instr_ready=1: instr_valid<=0, go to IDLE.
  - f_enable is low for at least 2 cycles between requests, so FETCH can clear ack.
- Minimum latency, selection to instr_valid, is 3 edges: IDLE to REQ, FETCH's 1-tick ack, REQ to HOLD.
- Redirect: on an edge with pc_wr=1, pc[pc_wr_thread]<=pc_wr_val and fault[pc_wr_thread]<=0. Redirect always beats the +1 increment.
  - Target is the thread in REQ: the request runs to f_ack, the data is discarded (instr_valid stays 0), the PC is not incremented, and the FSM goes to IDLE.
  - Target is the thread in HOLD: instr_valid<=0 (flush), go to IDLE.
  - Redirect on the same edge as f_ack for that thread: the instruction is dropped and the PC takes pc_wr_val.
  - Redirect to any other thread: only that PC changes.
- Multiple threads share one FETCH port; only one request is outstanding at a time.

Test Plan:
- Reset with thread_en=4'b0001 → f_enable=1, f_addr=0, f_thread=0 one edge after rst falls; f_ack with f_data=32'hDEAD_0001 → instr_valid=1, instr=32'hDEAD_0001, instr_pc=0; instr_ready=1 → next fetch at f_addr=1.
- thread_en=4'b0101 with instr_ready tied to 1 → f_thread sequence 0,2,0,2; each thread's addresses increment independently.
- Hold instr_ready=0 for 5 cycles in HOLD → instr, instr_pc, instr_thread unchanged and f_enable stays 0; release → one transfer only.
- Thread 1 at pc=5 in REQ, pc_wr to thread 1 with 32'h40 on the same edge as f_ack → no instr_valid; next thread-1 fetch at f_addr=32'h40.
- pc_wr sets thread 3 PC to 32'hFFFF_FFF2 with thread_en=4'b1000 → fault[3]=1, f_enable never asserts; pc_wr to 32'h10 → fault[3]=0, fetch at f_addr=32'h10.
- Assert rst mid-REQ → f_enable and instr_valid drop before the next clk edge; all PCs back to RESET_PC.
